// File: rtl/fas_frame_if.sv
// Handshake bundle between the FAS sequencer and the FIR/frame-buffer/FFT/analysis datapath.
// master = sequencer side, slave = datapath side.
interface fas_frame_if #(
  parameter int AW = 4
);
  logic          data_valid;
  logic          fir_valid;
  logic [AW-1:0] frame_addr;
  logic          frame_bank;
  logic          fft_start;
  logic          fft_bank;
  logic          fft_done;
  logic          fft_valid;
  logic          ana_start;
  logic          ana_done;
  logic          done;
  logic          overrun;

  modport master (
    input  data_valid, fft_done, ana_done,
    output fir_valid, frame_addr, frame_bank, fft_start, fft_bank,
           fft_valid, ana_start, done, overrun
  );

  modport slave (
    output data_valid, fft_done, ana_done,
    input  fir_valid, frame_addr, frame_bank, fft_start, fft_bank,
           fft_valid, ana_start, done, overrun
  );
endinterface

// File: rtl/fas_frame_ctrl.sv
// FAS FIR -> FFT -> analysis sequencer: FIR fill tracking, 2-bank frame packing,
// single-frame pending queue with sticky overrun, and the FFT/analysis launch FSM.
module fas_frame_ctrl #(
  parameter int TAPS    = 32,
  parameter int FIR_LAT = 2,
  parameter int FRAME   = 16
) (
  input  logic          clk,
  input  logic          rst,
  fas_frame_if.master   bus
);
  localparam int AW = $clog2(FRAME);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FFT_RUN = 2'd1,
    ANA_RUN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [5:0]           fill_q, fill_d;
  logic [FIR_LAT-1:0]   vpipe_q, vpipe_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic                 pend_q, pend_d;
  logic                 overrun_q, overrun_d;
  logic                 fft_start_q, fft_start_d;
  logic                 fft_bank_q, fft_bank_d;
  logic                 fft_valid_q, fft_valid_d;
  logic                 ana_start_q, ana_start_d;
  logic                 done_q, done_d;

  logic fill_full;
  logic fir_valid;
  logic complete;
  logic launch;

  always_comb begin
    fill_full = (fill_q == 6'(TAPS - 1));
    fill_d    = fill_q;
    if (bus.data_valid && !fill_full) fill_d = fill_q + 6'd1;

    // FIR result for a sample appears FIR_LAT cycles after its data_valid
    vpipe_d    = vpipe_q << 1;
    vpipe_d[0] = bus.data_valid & fill_full;
    fir_valid  = vpipe_q[FIR_LAT-1];

    complete  = fir_valid && (wr_addr_q == AW'(FRAME - 1));
    launch    = (state_q == IDLE) && pend_q;
    wr_addr_d = fir_valid ? wr_addr_q + AW'(1) : wr_addr_q;
    pend_d    = (pend_q & ~launch) | complete;

    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    overrun_d = overrun_q;
    if (complete) begin
      if (!(pend_q && !launch)) begin
        rd_bank_d = wr_bank_q;
        wr_bank_d = ~wr_bank_q;
      end else begin
        // slot occupied: drop this frame and reuse its bank for the next one
        overrun_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    fft_start_d = 1'b0;
    fft_bank_d  = fft_bank_q;
    fft_valid_d = 1'b0;
    ana_start_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          fft_start_d = 1'b1;
          fft_bank_d  = rd_bank_q;
          state_d     = FFT_RUN;
        end
      end
      FFT_RUN: begin
        if (bus.fft_done) begin
          fft_valid_d = 1'b1;
          ana_start_d = 1'b1;
          state_d     = ANA_RUN;
        end
      end
      ANA_RUN: begin
        if (bus.ana_done) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      fill_q      <= '0;
      vpipe_q     <= '0;
      wr_addr_q   <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      pend_q      <= 1'b0;
      overrun_q   <= 1'b0;
      fft_start_q <= 1'b0;
      fft_bank_q  <= 1'b0;
      fft_valid_q <= 1'b0;
      ana_start_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      vpipe_q     <= vpipe_d;
      wr_addr_q   <= wr_addr_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      pend_q      <= pend_d;
      overrun_q   <= overrun_d;
      fft_start_q <= fft_start_d;
      fft_bank_q  <= fft_bank_d;
      fft_valid_q <= fft_valid_d;
      ana_start_q <= ana_start_d;
      done_q      <= done_d;
    end
  end

  assign bus.fir_valid  = fir_valid;
  assign bus.frame_addr = wr_addr_q;
  assign bus.frame_bank = wr_bank_q;
  assign bus.fft_start  = fft_start_q;
  assign bus.fft_bank   = fft_bank_q;
  assign bus.fft_valid  = fft_valid_q;
  assign bus.ana_start  = ana_start_q;
  assign bus.done       = done_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_fas_frame_ctrl.sv
// Directed bench for fas_frame_ctrl: table of post-stream cycle vectors plus
// hand-written sequences for fill, pending/overrun, coincident launch and reset.
module tb_fas_frame_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  fas_frame_if bus ();

  fas_frame_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       dv;
    logic       fd;
    logic       ad;
    logic [11:0] exp;
  } vec_t;

  vec_t vt[13];

  // packed order: fir_valid, frame_addr[3:0], frame_bank, fft_start, fft_bank,
  // fft_valid, ana_start, done, overrun
  function automatic logic [11:0] mk(bit fir, int addr, bit fbank, bit fs, bit fb,
                                      bit fv, bit as_, bit dn, bit ov);
    logic [3:0] a;
    a = addr[3:0];
    return {fir, a, fbank, fs, fb, fv, as_, dn, ov};
  endfunction

  function automatic logic [11:0] obs();
    return {bus.fir_valid, bus.frame_addr, bus.frame_bank, bus.fft_start, bus.fft_bank,
            bus.fft_valid, bus.ana_start, bus.done, bus.overrun};
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step(logic dv, logic fd, logic ad);
    bus.data_valid = dv;
    bus.fft_done   = fd;
    bus.ana_done   = ad;
    @(posedge clk);
    @(negedge clk);
    bus.data_valid = 1'b0;
    bus.fft_done   = 1'b0;
    bus.ana_done   = 1'b0;
  endtask

  task automatic prime();
    int cnt;
    cnt = 0;
    for (int i = 0; i < 31; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (bus.fir_valid) cnt++;
    end
    chk("prime_no_fir", cnt, 0);
  endtask

  // 16 back-to-back samples then 2 idle cycles; checks every write of the frame
  task automatic frame16(bit exp_bank);
    int seen;
    seen = 0;
    for (int i = 0; i < 18; i++) begin
      step(i < 16, 1'b0, 1'b0);
      if (bus.fir_valid) begin
        chk("frame_addr", bus.frame_addr, seen);
        chk("frame_bank_wr", bus.frame_bank, exp_bank);
        seen++;
      end
    end
    chk("frame_writes", seen, 16);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] base;
    base = mk(0, 0, 1, 0, 0, 0, 0, 0, 0);
    vt[0]  = '{"wr_addr15",  1'b0, 1'b0, 1'b0, mk(1, 15, 0, 0, 0, 0, 0, 0, 0)};
    vt[1]  = '{"bank_toggle", 1'b0, 1'b0, 1'b0, base};
    vt[2]  = '{"fft_start",  1'b0, 1'b0, 1'b0, mk(0, 0, 1, 1, 0, 0, 0, 0, 0)};
    vt[3]  = '{"start_1cyc", 1'b0, 1'b0, 1'b0, base};
    vt[4]  = '{"fft_valid",  1'b0, 1'b1, 1'b0, mk(0, 0, 1, 0, 0, 1, 1, 0, 0)};
    vt[5]  = '{"stray_fd",   1'b0, 1'b1, 1'b0, base};
    vt[6]  = '{"ana_wait1",  1'b0, 1'b0, 1'b0, base};
    vt[7]  = '{"ana_wait2",  1'b0, 1'b0, 1'b0, base};
    vt[8]  = '{"ana_wait3",  1'b0, 1'b0, 1'b0, base};
    vt[9]  = '{"done",       1'b0, 1'b0, 1'b1, mk(0, 0, 1, 0, 0, 0, 0, 1, 0)};
    vt[10] = '{"done_1cyc",  1'b0, 1'b0, 1'b0, base};
    vt[11] = '{"ad_in_idle", 1'b0, 1'b0, 1'b1, base};
    vt[12] = '{"fd_in_idle", 1'b0, 1'b1, 1'b0, base};

    bus.data_valid = 1'b0;
    bus.fft_done   = 1'b0;
    bus.ana_done   = 1'b0;
    #1;
    chk("reset_outputs", obs(), 12'h000);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // fill then first frame: fir_valid two cycles after the 32nd sample
    for (int k = 1; k <= 47; k++) begin
      step(1'b1, 1'b0, 1'b0);
      chk($sformatf("stream_k%0d", k), obs(),
          mk(k >= 33, (k >= 33) ? k - 33 : 0, 0, 0, 0, 0, 0, 0, 0));
    end

    foreach (vt[i]) begin
      step(vt[i].dv, vt[i].fd, vt[i].ad);
      chk(vt[i].name, obs(), vt[i].exp);
    end

    // pending frame, then an overrun while the FFT is stalled
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    prime();
    frame16(1'b0);
    chk("t5_bank_after_f1", bus.frame_bank, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("t5_start_f1", obs(), mk(0, 0, 1, 1, 0, 0, 0, 0, 0));
    frame16(1'b1);
    chk("t5_pend_f2", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    frame16(1'b0);
    chk("t5_overrun", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    step(1'b0, 1'b1, 1'b0);
    chk("t5_fft_valid", obs(), mk(0, 0, 0, 0, 0, 1, 1, 0, 1));
    step(1'b0, 1'b0, 1'b1);
    chk("t5_done", obs(), mk(0, 0, 0, 0, 0, 0, 0, 1, 1));
    step(1'b0, 1'b0, 1'b0);
    chk("t5_start_pending", obs(), mk(0, 0, 0, 1, 1, 0, 0, 0, 1));

    // reset in the middle of a stream with FIR results in flight
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    bus.data_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("t1_rst_outputs", obs(), 12'h000);
    @(negedge clk);
    rst = 1'b0;
    bus.data_valid = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    chk("t1_pipe_cleared", obs(), 12'h000);
    step(1'b0, 1'b0, 1'b0);
    chk("t1_pipe_cleared2", obs(), 12'h000);

    // frame completion in the very cycle a pending frame launches
    prime();
    frame16(1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("t6_start_f1", obs(), mk(0, 0, 1, 1, 0, 0, 0, 0, 0));
    frame16(1'b1);
    step(1'b0, 1'b1, 1'b0);
    chk("t6_fft_valid", obs(), mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("t6_done_and_wr15", obs(), mk(1, 15, 0, 0, 0, 0, 0, 1, 0));
    step(1'b0, 1'b0, 1'b0);
    chk("t6_launch_f2", obs(), mk(0, 0, 1, 1, 1, 0, 0, 0, 0));
    step(1'b0, 1'b1, 1'b0);
    chk("t6_fft_valid2", obs(), mk(0, 0, 1, 0, 1, 1, 1, 0, 0));
    step(1'b0, 1'b0, 1'b1);
    chk("t6_done2", obs(), mk(0, 0, 1, 0, 1, 0, 0, 1, 0));
    step(1'b0, 1'b0, 1'b0);
    chk("t6_launch_f3", obs(), mk(0, 0, 1, 1, 0, 0, 0, 0, 0));
    step(1'b0, 1'b0, 1'b0);
    chk("t6_idle_after", obs(), mk(0, 0, 1, 0, 0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
